// File: rtl/byte_striping.sv
// byte_striping: deals a valid-qualified word stream alternately onto two registered lanes,
// flushing a leftover even word alone on the first idle cycle so nothing is stranded.
module byte_striping #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic [DATA_WIDTH-1:0] lane_0,
    output logic                  valid_0,
    output logic [DATA_WIDTH-1:0] lane_1,
    output logic                  valid_1
);
    typedef enum logic {EVEN, ODD} state_t;
    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [DATA_WIDTH-1:0] lane_0_q, lane_0_d;
    logic [DATA_WIDTH-1:0] lane_1_q, lane_1_d;
    logic                  valid_0_q, valid_0_d;
    logic                  valid_1_q, valid_1_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EVEN;
            hold_q    <= '0;
            lane_0_q  <= '0;
            lane_1_q  <= '0;
            valid_0_q <= 1'b0;
            valid_1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            lane_0_q  <= lane_0_d;
            lane_1_q  <= lane_1_d;
            valid_0_q <= valid_0_d;
            valid_1_q <= valid_1_d;
        end
    end

    always_comb begin
        state_d = (state_q == EVEN && valid_in) ? ODD : EVEN;
    end

    // In ODD the parked word always leaves, paired if a new word arrives, alone otherwise.
    always_comb begin
        hold_d    = (state_q == EVEN && valid_in) ? data_in : hold_q;
        lane_0_d  = (state_q == ODD) ? hold_q : lane_0_q;
        lane_1_d  = (state_q == ODD && valid_in) ? data_in : lane_1_q;
        valid_0_d = (state_q == ODD);
        valid_1_d = (state_q == ODD) && valid_in;
    end

    assign lane_0  = lane_0_q;
    assign lane_1  = lane_1_q;
    assign valid_0 = valid_0_q;
    assign valid_1 = valid_1_q;
endmodule
